// File: rtl/mmio_pkg.sv
// Shared address map and UART_CTRL bit layout for the 0x8xxx_xxxx MMIO responder.
package mmio_pkg;

    localparam logic [3:0] MMIO_REGION = 4'h8;

    localparam logic [7:0] UART_CTRL = 8'h00;
    localparam logic [7:0] UART_RX   = 8'h04;
    localparam logic [7:0] UART_TX   = 8'h08;
    localparam logic [7:0] CYCLE_CNT = 8'h10;
    localparam logic [7:0] INSTR_CNT = 8'h14;
    localparam logic [7:0] CNT_CLR   = 8'h18;

    localparam int CTRL_TX_RDY   = 0;
    localparam int CTRL_RX_AVAIL = 1;
    localparam int CTRL_TX_DROP  = 2;
    localparam int CTRL_RX_OVR   = 3;

endpackage

// File: rtl/mmio_rx_fifo.sv
// Receive FIFO: extra-MSB pointers, full/empty from the MSB compare, no read bypass.
module mmio_rx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // A pop frees the slot this cycle, so a push into a full FIFO is accepted alongside it.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign wr_ptr_d = wr_ptr_q + (AW+1)'(do_push);
    assign rd_ptr_d = rd_ptr_q + (AW+1)'(do_pop);
    assign dout     = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/uart_mmio_responder.sv
// MMIO responder for the 0x8xxx_xxxx region: UART TX holding register, RX FIFO, sticky flags,
// and (when MMIO_COUNTERS_EN is defined) cycle / retired-instruction counters.
module uart_mmio_responder
    import mmio_pkg::*;
#(
    parameter int RX_DEPTH  = 8,
    parameter int CNT_WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic        mem_we,
    input  logic        mem_re,
    output logic [31:0] mem_rdata,
    input  logic        instr_retire,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid
);

    logic        hit;
    logic [7:0]  off;
    logic        rd_ctrl, rd_rx, wr_tx;
    logic [7:0]  fifo_dout;
    logic        fifo_full, fifo_empty, pop_fire;

    logic [31:0] mem_rdata_q, mem_rdata_d;
    logic        tx_valid_q, tx_valid_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_drop_q, tx_drop_d;
    logic        rx_ovr_q, rx_ovr_d;
    logic [31:0] ctrl_word;
    logic [31:0] cycle_rd, instr_rd;
    logic        unused_bits;

    assign hit      = (mem_addr[31:28] == MMIO_REGION);
    assign off      = mem_addr[7:0];
    assign rd_ctrl  = mem_re && hit && (off == UART_CTRL);
    assign rd_rx    = mem_re && hit && (off == UART_RX);
    assign wr_tx    = mem_we && hit && (off == UART_TX);
    assign pop_fire = rd_rx && !fifo_empty;

    assign unused_bits = ^{mem_addr[27:8], mem_wdata[31:8]};

    mmio_rx_fifo #(
        .DEPTH (RX_DEPTH),
        .WIDTH (8)
    ) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_valid),
        .din   (rx_data),
        .pop   (rd_rx),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

`ifdef MMIO_COUNTERS_EN
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

    logic [CNT_WIDTH-1:0] cycle_q, instr_q;
    logic                 wr_clr;

    assign wr_clr = mem_we && hit && (off == CNT_CLR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_q <= '0;
            instr_q <= '0;
        end else if (wr_clr) begin
            cycle_q <= '0;
            instr_q <= '0;
        end else begin
            cycle_q <= cycle_q + CNT_ONE;
            if (instr_retire) begin
                instr_q <= instr_q + CNT_ONE;
            end
        end
    end

    always_comb begin
        cycle_rd = '0;
        instr_rd = '0;
        cycle_rd[CNT_WIDTH-1:0] = cycle_q;
        instr_rd[CNT_WIDTH-1:0] = instr_q;
    end
`else
    logic unused_retire;

    assign unused_retire = instr_retire;
    assign cycle_rd      = '0;
    assign instr_rd      = '0;
`endif

    always_comb begin
        ctrl_word = '0;
        ctrl_word[CTRL_TX_RDY]   = !tx_valid_q;
        ctrl_word[CTRL_RX_AVAIL] = !fifo_empty;
        ctrl_word[CTRL_TX_DROP]  = tx_drop_q;
        ctrl_word[CTRL_RX_OVR]   = rx_ovr_q;
    end

    // NOTE: every next-state signal gets a default first so no path through the block infers a latch.
    always_comb begin
        mem_rdata_d = mem_rdata_q;
        if (mem_re) begin
            mem_rdata_d = '0;
            if (hit) begin
                case (off)
                    UART_CTRL: mem_rdata_d = ctrl_word;
                    UART_RX:   mem_rdata_d = fifo_empty ? 32'h0 : {24'h0, fifo_dout};
                    CYCLE_CNT: mem_rdata_d = cycle_rd;
                    INSTR_CNT: mem_rdata_d = instr_rd;
                    default:   mem_rdata_d = '0;
                endcase
            end
        end

        // A write landing on the acceptance edge still sees the busy register and is dropped.
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        if (tx_valid_q && tx_ready) begin
            tx_valid_d = 1'b0;
        end
        if (wr_tx && !tx_valid_q) begin
            tx_valid_d = 1'b1;
            tx_data_d  = mem_wdata[7:0];
        end

        // Set events take priority over a same-cycle clearing read.
        tx_drop_d = (tx_drop_q && !rd_ctrl) || (wr_tx && tx_valid_q);
        rx_ovr_d  = (rx_ovr_q && !rd_ctrl) || (rx_valid && fifo_full && !pop_fire);
    end

    // NOTE: state registers use non-blocking assignments so all of them update from the same pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_rdata_q <= '0;
            tx_valid_q  <= 1'b0;
            tx_data_q   <= '0;
            tx_drop_q   <= 1'b0;
            rx_ovr_q    <= 1'b0;
        end else begin
            mem_rdata_q <= mem_rdata_d;
            tx_valid_q  <= tx_valid_d;
            tx_data_q   <= tx_data_d;
            tx_drop_q   <= tx_drop_d;
            rx_ovr_q    <= rx_ovr_d;
        end
    end

    assign mem_rdata = mem_rdata_q;
    assign tx_valid  = tx_valid_q;
    assign tx_data   = tx_data_q;

endmodule

// File: tb/tb_uart_mmio_responder.sv
// Self-checking bench for uart_mmio_responder: directed vector table, reset sequence, and
// randomized traffic compared against a queue-based reference model.
module tb_uart_mmio_responder;

    localparam int RX_DEPTH = 8;

    localparam logic [31:0] A_CTRL  = 32'h8000_0000;
    localparam logic [31:0] A_RX    = 32'h8000_0004;
    localparam logic [31:0] A_TX    = 32'h8000_0008;
    localparam logic [31:0] A_CYC   = 32'h8000_0010;
    localparam logic [31:0] A_INS   = 32'h8000_0014;
    localparam logic [31:0] A_CLR   = 32'h8000_0018;
    localparam logic [31:0] A_NOHIT = 32'h0000_0004;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic        mem_we = 1'b0;
    logic        mem_re = 1'b0;
    logic [31:0] mem_rdata;
    logic        instr_retire = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;

    int checks = 0;
    int failures = 0;

    uart_mmio_responder #(
        .RX_DEPTH  (RX_DEPTH),
        .CNT_WIDTH (32)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_we       (mem_we),
        .mem_re       (mem_re),
        .mem_rdata    (mem_rdata),
        .instr_retire (instr_retire),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [7:0]  m_q[$];
    logic        m_pend;
    logic [7:0]  m_byte;
    logic        m_drop;
    logic        m_ovr;
    logic [31:0] m_cyc;
    logic [31:0] m_ins;
    logic [31:0] m_rdata;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_pend  = 1'b0;
        m_byte  = '0;
        m_drop  = 1'b0;
        m_ovr   = 1'b0;
        m_cyc   = '0;
        m_ins   = '0;
        m_rdata = '0;
    endtask

    // One clock of register-map semantics, evaluated from the inputs presented this cycle.
    task automatic model_step();
        logic       h;
        logic [7:0] o;
        bit         ctrl_rd, popped, tx_wr, clr, full_now;
        int         n;
        h  = (mem_addr[31:28] == 4'h8);
        o  = mem_addr[7:0];
        n  = m_q.size();
        ctrl_rd  = mem_re && h && (o == 8'h00);
        popped   = mem_re && h && (o == 8'h04) && (n > 0);
        tx_wr    = mem_we && h && (o == 8'h08);
        clr      = mem_we && h && (o == 8'h18);
        full_now = (n == RX_DEPTH);
        if (mem_re) begin
            m_rdata = 32'h0;
            if (h) begin
                if (o == 8'h00) m_rdata = {28'h0, m_ovr, m_drop, (n != 0), !m_pend};
                if (o == 8'h04 && n > 0) m_rdata = {24'h0, m_q[0]};
`ifdef MMIO_COUNTERS_EN
                if (o == 8'h10) m_rdata = m_cyc;
                if (o == 8'h14) m_rdata = m_ins;
`endif
            end
        end
        m_drop = (m_drop && !ctrl_rd) || (tx_wr && m_pend);
        m_ovr  = (m_ovr && !ctrl_rd) || (rx_valid && full_now && !popped);
        if (tx_wr && !m_pend) begin
            m_pend = 1'b1;
            m_byte = mem_wdata[7:0];
        end else if (m_pend && tx_ready) begin
            m_pend = 1'b0;
        end
        if (popped) void'(m_q.pop_front());
        if (rx_valid && m_q.size() < RX_DEPTH) m_q.push_back(rx_data);
        if (clr) begin
            m_cyc = '0;
            m_ins = '0;
        end else begin
            m_cyc = m_cyc + 1;
            if (instr_retire) m_ins = m_ins + 1;
        end
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        check("model_rdata", mem_rdata, m_rdata);
        check("model_tx_valid", {31'h0, tx_valid}, {31'h0, m_pend});
        if (m_pend) check("model_tx_data", {24'h0, tx_data}, {24'h0, m_byte});
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] w, input logic we, input logic re,
                         input logic ret, input logic trdy, input logic rxv, input logic [7:0] rxd);
        mem_addr = a; mem_wdata = w; mem_we = we; mem_re = re;
        instr_retire = ret; tx_ready = trdy; rx_valid = rxv; rx_data = rxd;
    endtask

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we, re, ret, trdy, rxv;
        logic [7:0]  rxd;
        logic        chk_rd;
        logic [31:0] exp_rd;
        logic        exp_txv;
        logic [7:0]  exp_txd;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string nm, input logic [31:0] a, input logic [31:0] w, input logic we,
                       input logic re, input logic ret, input logic trdy, input logic rxv,
                       input logic [7:0] rxd, input logic chk, input logic [31:0] er,
                       input logic etv, input logic [7:0] etd);
        vec_t v;
        v.name = nm; v.addr = a; v.wdata = w; v.we = we; v.re = re; v.ret = ret;
        v.trdy = trdy; v.rxv = rxv; v.rxd = rxd; v.chk_rd = chk; v.exp_rd = er;
        v.exp_txv = etv; v.exp_txd = etd;
        vecs.push_back(v);
    endtask

    logic [31:0] cnt3;
    logic [31:0] ins_before_clr;

    initial begin
`ifdef MMIO_COUNTERS_EN
        cnt3 = 32'd3;
`else
        cnt3 = 32'd0;
`endif
        ins_before_clr = cnt3;

        // 1: TX holding register held until accepted
        add("t1_write", A_TX, 32'h41, 1, 0, 0, 0, 0, 8'h0, 0, 0, 1, 8'h41);
        for (int i = 0; i < 5; i++) add("t1_hold", 0, 0, 0, 0, 0, 0, 0, 8'h0, 0, 0, 1, 8'h41);
        add("t1_accept", 0, 0, 0, 0, 0, 1, 0, 8'h0, 0, 0, 0, 8'h0);
        add("t1_ctrl", A_CTRL, 0, 0, 1, 0, 0, 0, 8'h0, 1, 32'h1, 0, 8'h0);
        // 2: back-to-back writes, second dropped
        add("t2_wr41", A_TX, 32'h41, 1, 0, 0, 0, 0, 8'h0, 0, 0, 1, 8'h41);
        add("t2_wr42", A_TX, 32'h42, 1, 0, 0, 0, 0, 8'h0, 0, 0, 1, 8'h41);
        add("t2_ctrl_drop", A_CTRL, 0, 0, 1, 0, 0, 0, 8'h0, 1, 32'h4, 1, 8'h41);
        add("t2_ctrl_clear", A_CTRL, 0, 0, 1, 0, 0, 0, 8'h0, 1, 32'h0, 1, 8'h41);
        // 3: overrun on the ninth push
        for (int i = 0; i < 9; i++) add("t3_push", 0, 0, 0, 0, 0, 0, 1, 8'(8'h10 + i), 0, 0, 1, 8'h41);
        add("t3_ctrl_ovr", A_CTRL, 0, 0, 1, 0, 0, 0, 8'h0, 1, 32'hA, 1, 8'h41);
        for (int i = 0; i < 8; i++) add("t3_pop", A_RX, 0, 0, 1, 0, 0, 0, 8'h0, 1, 32'h10 + i, 1, 8'h41);
        add("t3_pop_empty", A_RX, 0, 0, 1, 0, 0, 0, 8'h0, 1, 32'h0, 1, 8'h41);
        add("t3_ctrl_after", A_CTRL, 0, 0, 1, 0, 0, 0, 8'h0, 1, 32'h0, 1, 8'h41);
        // 4: push and pop together while full
        for (int i = 0; i < 8; i++) add("t4_fill", 0, 0, 0, 0, 0, 0, 1, 8'(8'h20 + i), 0, 0, 1, 8'h41);
        add("t4_pushpop", A_RX, 0, 0, 1, 0, 0, 1, 8'h55, 1, 32'h20, 1, 8'h41);
        add("t4_ctrl_noovr", A_CTRL, 0, 0, 1, 0, 0, 0, 8'h0, 1, 32'h2, 1, 8'h41);
        for (int i = 1; i < 8; i++) add("t4_pop", A_RX, 0, 0, 1, 0, 0, 0, 8'h0, 1, 32'h20 + i, 1, 8'h41);
        add("t4_pop_last", A_RX, 0, 0, 1, 0, 0, 0, 8'h0, 1, 32'h55, 1, 8'h41);
        add("t4_pop_empty", A_RX, 0, 0, 1, 0, 0, 0, 8'h0, 1, 32'h0, 1, 8'h41);
        // 5: instruction counter and clear priority
        for (int i = 0; i < 3; i++) add("t5_retire", 0, 0, 0, 0, 1, 0, 0, 8'h0, 0, 0, 1, 8'h41);
        add("t5_ins3", A_INS, 0, 0, 1, 0, 0, 0, 8'h0, 1, cnt3, 1, 8'h41);
        add("t5_clr_hold", A_CLR, 32'hDEAD, 1, 0, 1, 0, 0, 8'h0, 1, ins_before_clr, 1, 8'h41);
        add("t5_cyc0", A_CYC, 0, 0, 1, 0, 0, 0, 8'h0, 1, 32'h0, 1, 8'h41);
        add("t5_ins0", A_INS, 0, 0, 1, 0, 0, 0, 8'h0, 1, 32'h0, 1, 8'h41);
        // 6 prologue: three bytes queued with TX still pending
        for (int i = 0; i < 3; i++) add("t6_push", 0, 0, 0, 0, 0, 0, 1, 8'(8'h31 + i), 0, 0, 1, 8'h41);
        add("t6_ctrl", A_CTRL, 0, 0, 1, 0, 0, 0, 8'h0, 1, 32'h2, 1, 8'h41);

        // Power-on reset
        model_reset();
        #3;
        check("reset_rdata", mem_rdata, 32'h0);
        check("reset_tx_valid", {31'h0, tx_valid}, 32'h0);
        check("reset_tx_data", {24'h0, tx_data}, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].addr, vecs[i].wdata, vecs[i].we, vecs[i].re, vecs[i].ret,
                  vecs[i].trdy, vecs[i].rxv, vecs[i].rxd);
            step();
            if (vecs[i].chk_rd) check(vecs[i].name, mem_rdata, vecs[i].exp_rd);
            check({vecs[i].name, "_txv"}, {31'h0, tx_valid}, {31'h0, vecs[i].exp_txv});
            if (vecs[i].exp_txv) check({vecs[i].name, "_txd"}, {24'h0, tx_data}, {24'h0, vecs[i].exp_txd});
        end
        drive(0, 0, 0, 0, 0, 0, 0, 8'h0);

        // 6: asynchronous reset mid-operation
        #2;
        rst = 1'b1;
        #1;
        check("t6_rst_rdata", mem_rdata, 32'h0);
        check("t6_rst_tx_valid", {31'h0, tx_valid}, 32'h0);
        check("t6_rst_tx_data", {24'h0, tx_data}, 32'h0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        drive(A_CTRL, 0, 0, 1, 0, 0, 0, 8'h0);
        step();
        check("t6_ctrl_after_rst", mem_rdata, 32'h1);
        drive(A_NOHIT, 0, 0, 1, 0, 0, 0, 8'h0);
        step();
        check("t6_nohit_read", mem_rdata, 32'h0);
        drive(A_RX, 0, 0, 1, 0, 0, 0, 8'h0);
        step();
        check("t6_rx_empty", mem_rdata, 32'h0);

        // Randomized traffic against the reference model
        for (int i = 0; i < 3000; i++) begin
            logic [7:0]  offs [8];
            logic [31:0] a;
            offs[0] = 8'h00; offs[1] = 8'h04; offs[2] = 8'h08; offs[3] = 8'h0C;
            offs[4] = 8'h10; offs[5] = 8'h14; offs[6] = 8'h18; offs[7] = 8'hFF;
            a = {4'h8, 20'($urandom), offs[$urandom_range(0, 7)]};
            if ($urandom_range(0, 7) == 0) a[31:28] = 4'($urandom_range(0, 7));
            drive(a, $urandom, ($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 4),
                  1'($urandom), ($urandom_range(0, 9) < 4), ($urandom_range(0, 9) < 4), 8'($urandom));
            step();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 8'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
